id_ex_register: RTL and testbench

Pipeline register between instruction decode and execution in the 5-stage MIPS core. It captures the decode-stage control bundle (WB/M/EX groups) together with operands, immediate and register specifiers. It detects load-use hazards against the instruction currently held, and inserts a bubble while requesting a stall upstream. It also honours a flush from the branch-resolution logic.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/load_use_detector.sv | 25 ++
 rtl/id_ex_register.sv | 158 +++++++++++++++
 tb/tb_id_ex_register.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core.
// Holds opcode constants, ALUOp encodings, the layout of the pipelined
// control bundle (WB/M/EX groups) and the all-zero NOP bundle used for bubbles.
package mips_pkg;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   // ALU operation classes carried in the EX group
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam int CTRL_W = 9;

   // Control bundle: WB group, M group, EX group (MSB to LSB)
   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      logic       reg_dst;
      logic       alu_src;
      logic [1:0] alu_op;
   } ctrl_t;

   // A bubble is an all-zero bundle: no register-file or memory write
   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detector.
// Ports:
//   ex_valid    - EX stage holds a real instruction
//   ex_mem_read - instruction in EX is a load
//   ex_rt       - load destination register in EX
//   id_rs/id_rt - source specifiers of the instruction in ID
//   id_valid    - ID stage holds a real instruction
//   stall       - hold PC and IF/ID, insert a bubble into EX
module load_use_detector (
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_valid,
   output logic       stall
);

   logic rt_match;

   // $0 is hardwired to zero, so a load targeting it can never create a hazard
   assign rt_match = (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
   assign stall    = ex_valid && ex_mem_read && rt_match && id_valid;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register of the 5-stage MIPS core.
// Captures the decode control bundle, operands, immediate and register
// specifiers; inserts a bubble on load-use hazards (raising stall_out) and on
// flush from branch resolution.
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   id_valid_in               - decode stage holds a real instruction
//   wb_*/m_*/ex_*_in          - control bundle from decode
//   pc_plus4/rd_data1/rd_data2/imm_ext_in - datapath words (B bits)
//   rs/rt/rd_in               - register specifiers
//   flush_in                  - squash the instruction entering EX
//   stall_out                 - combinational load-use stall request
//   ex_valid_out, *_out       - registered copies of the inputs
module id_ex_register
   import mips_pkg::*;
#(
   parameter int B = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         id_valid_in,
   input  logic         wb_RegWrite_in,
   input  logic         wb_MemtoReg_in,
   input  logic         m_Branch_in,
   input  logic         m_MemRead_in,
   input  logic         m_MemWrite_in,
   input  logic         ex_RegDst_in,
   input  logic         ex_ALUSrc_in,
   input  logic [1:0]   ex_ALUOp_in,
   input  logic [B-1:0] pc_plus4_in,
   input  logic [B-1:0] rd_data1_in,
   input  logic [B-1:0] rd_data2_in,
   input  logic [B-1:0] imm_ext_in,
   input  logic [4:0]   rs_in,
   input  logic [4:0]   rt_in,
   input  logic [4:0]   rd_in,
   input  logic         flush_in,
   output logic         stall_out,
   output logic         ex_valid_out,
   output logic         wb_RegWrite_out,
   output logic         wb_MemtoReg_out,
   output logic         m_Branch_out,
   output logic         m_MemRead_out,
   output logic         m_MemWrite_out,
   output logic         ex_RegDst_out,
   output logic         ex_ALUSrc_out,
   output logic [1:0]   ex_ALUOp_out,
   output logic [B-1:0] pc_plus4_out,
   output logic [B-1:0] rd_data1_out,
   output logic [B-1:0] rd_data2_out,
   output logic [B-1:0] imm_ext_out,
   output logic [4:0]   rs_out,
   output logic [4:0]   rt_out,
   output logic [4:0]   rd_out
);

   ctrl_t          ctrl_in;
   ctrl_t          ctrl_d, ctrl_q;
   logic           valid_d, valid_q;
   logic [B-1:0]   pc_plus4_d, pc_plus4_q;
   logic [B-1:0]   rd_data1_d, rd_data1_q;
   logic [B-1:0]   rd_data2_d, rd_data2_q;
   logic [B-1:0]   imm_ext_d, imm_ext_q;
   logic [4:0]     rs_d, rs_q;
   logic [4:0]     rt_d, rt_q;
   logic [4:0]     rd_d, rd_q;
   logic           stall;
   logic           bubble;

   assign ctrl_in = '{reg_write:  wb_RegWrite_in,
                      mem_to_reg: wb_MemtoReg_in,
                      branch:     m_Branch_in,
                      mem_read:   m_MemRead_in,
                      mem_write:  m_MemWrite_in,
                      reg_dst:    ex_RegDst_in,
                      alu_src:    ex_ALUSrc_in,
                      alu_op:     ex_ALUOp_in};

   load_use_detector u_load_use_detector (
      .ex_valid    (valid_q),
      .ex_mem_read (ctrl_q.mem_read),
      .ex_rt       (rt_q),
      .id_rs       (rs_in),
      .id_rt       (rt_in),
      .id_valid    (id_valid_in),
      .stall       (stall)
   );

   // Flush and hazard both load the same bubble, so a coincident pair costs one
   assign bubble = flush_in || stall;

   always_comb begin
      ctrl_d     = ctrl_in;
      valid_d    = id_valid_in;
      pc_plus4_d = pc_plus4_in;
      rd_data1_d = rd_data1_in;
      rd_data2_d = rd_data2_in;
      imm_ext_d  = imm_ext_in;
      rs_d       = rs_in;
      rt_d       = rt_in;
      rd_d       = rd_in;
      if (bubble) begin
         // Data fields are don't-care in a bubble; zero them for clean waveforms
         ctrl_d     = CTRL_NOP;
         valid_d    = 1'b0;
         pc_plus4_d = '0;
         rd_data1_d = '0;
         rd_data2_d = '0;
         imm_ext_d  = '0;
         rs_d       = '0;
         rt_d       = '0;
         rd_d       = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q     <= CTRL_NOP;
         valid_q    <= 1'b0;
         pc_plus4_q <= '0;
         rd_data1_q <= '0;
         rd_data2_q <= '0;
         imm_ext_q  <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         valid_q    <= valid_d;
         pc_plus4_q <= pc_plus4_d;
         rd_data1_q <= rd_data1_d;
         rd_data2_q <= rd_data2_d;
         imm_ext_q  <= imm_ext_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         rd_q       <= rd_d;
      end
   end

   assign stall_out       = stall;
   assign ex_valid_out    = valid_q;
   assign wb_RegWrite_out = ctrl_q.reg_write;
   assign wb_MemtoReg_out = ctrl_q.mem_to_reg;
   assign m_Branch_out    = ctrl_q.branch;
   assign m_MemRead_out   = ctrl_q.mem_read;
   assign m_MemWrite_out  = ctrl_q.mem_write;
   assign ex_RegDst_out   = ctrl_q.reg_dst;
   assign ex_ALUSrc_out   = ctrl_q.alu_src;
   assign ex_ALUOp_out    = ctrl_q.alu_op;
   assign pc_plus4_out    = pc_plus4_q;
   assign rd_data1_out    = rd_data1_q;
   assign rd_data2_out    = rd_data2_q;
   assign imm_ext_out     = imm_ext_q;
   assign rs_out          = rs_q;
   assign rt_out          = rt_q;
   assign rd_out          = rd_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: directed scenarios followed by
// random instruction streams, compared against a behavioural pipeline model.
module tb_id_ex_register;

   // Control bundle bit order: RegWrite MemtoReg Branch MemRead MemWrite RegDst ALUSrc ALUOp[1:0]
   localparam logic [8:0] C_RTYPE = 9'b1_0_0_0_0_1_0_10;
   localparam logic [8:0] C_LW    = 9'b1_1_0_1_0_0_1_00;
   localparam logic [8:0] C_SW    = 9'b0_0_0_0_1_0_1_00;
   localparam logic [8:0] C_BEQ   = 9'b0_0_1_0_0_0_0_01;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic [8:0]  i_ctrl;
   logic [31:0] i_pc, i_d1, i_d2, i_imm;
   logic [4:0]  i_rs, i_rt, i_rd;
   logic        i_flush;

   logic        stall_out, ex_valid_out;
   logic        wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_MemRead_out;
   logic        m_MemWrite_out, ex_RegDst_out, ex_ALUSrc_out;
   logic [1:0]  ex_ALUOp_out;
   logic [31:0] pc_plus4_out, rd_data1_out, rd_data2_out, imm_ext_out;
   logic [4:0]  rs_out, rt_out, rd_out;

   // Model of the instruction sitting in EX
   logic        m_valid;
   logic [8:0]  m_ctrl;
   logic [31:0] m_pc, m_d1, m_d2, m_imm;
   logic [4:0]  m_rs, m_rt, m_rd;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   id_ex_register #(.B(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_valid_in     (i_valid),
      .wb_RegWrite_in  (i_ctrl[8]),
      .wb_MemtoReg_in  (i_ctrl[7]),
      .m_Branch_in     (i_ctrl[6]),
      .m_MemRead_in    (i_ctrl[5]),
      .m_MemWrite_in   (i_ctrl[4]),
      .ex_RegDst_in    (i_ctrl[3]),
      .ex_ALUSrc_in    (i_ctrl[2]),
      .ex_ALUOp_in     (i_ctrl[1:0]),
      .pc_plus4_in     (i_pc),
      .rd_data1_in     (i_d1),
      .rd_data2_in     (i_d2),
      .imm_ext_in      (i_imm),
      .rs_in           (i_rs),
      .rt_in           (i_rt),
      .rd_in           (i_rd),
      .flush_in        (i_flush),
      .stall_out       (stall_out),
      .ex_valid_out    (ex_valid_out),
      .wb_RegWrite_out (wb_RegWrite_out),
      .wb_MemtoReg_out (wb_MemtoReg_out),
      .m_Branch_out    (m_Branch_out),
      .m_MemRead_out   (m_MemRead_out),
      .m_MemWrite_out  (m_MemWrite_out),
      .ex_RegDst_out   (ex_RegDst_out),
      .ex_ALUSrc_out   (ex_ALUSrc_out),
      .ex_ALUOp_out    (ex_ALUOp_out),
      .pc_plus4_out    (pc_plus4_out),
      .rd_data1_out    (rd_data1_out),
      .rd_data2_out    (rd_data2_out),
      .imm_ext_out     (imm_ext_out),
      .rs_out          (rs_out),
      .rt_out          (rt_out),
      .rd_out          (rd_out)
   );

   function automatic logic [152:0] dut_vec();
      return {ex_valid_out, wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out,
              m_MemRead_out, m_MemWrite_out, ex_RegDst_out, ex_ALUSrc_out,
              ex_ALUOp_out, pc_plus4_out, rd_data1_out, rd_data2_out,
              imm_ext_out, rs_out, rt_out, rd_out};
   endfunction

   function automatic logic [152:0] model_vec();
      return {m_valid, m_ctrl, m_pc, m_d1, m_d2, m_imm, m_rs, m_rt, m_rd};
   endfunction

   // A valid load in EX whose (non-$0) destination is read by the valid ID instruction
   function automatic logic model_stall();
      logic ex_is_load;
      logic id_reads_it;
      ex_is_load  = m_valid && m_ctrl[5];
      id_reads_it = (m_rt != 5'd0) && (m_rt == i_rs || m_rt == i_rt);
      return ex_is_load && id_reads_it && i_valid;
   endfunction

   task automatic model_clear();
      m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_d1 = '0; m_d2 = '0;
      m_imm = '0; m_rs = '0; m_rt = '0; m_rd = '0;
   endtask

   task automatic model_load();
      m_valid = i_valid; m_ctrl = i_ctrl; m_pc = i_pc; m_d1 = i_d1; m_d2 = i_d2;
      m_imm = i_imm; m_rs = i_rs; m_rt = i_rt; m_rd = i_rd;
   endtask

   task automatic chk(input string tag, input logic [152:0] obs, input logic [152:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic valid, input logic [8:0] ctrl, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic flush);
      i_valid = valid; i_ctrl = ctrl; i_rs = rs; i_rt = rt; i_rd = rd; i_flush = flush;
      i_pc = $urandom; i_d1 = $urandom; i_d2 = $urandom; i_imm = $urandom;
   endtask

   // Called at a falling edge with inputs already driven; ends at the next falling edge
   task automatic cycle(input string tag);
      logic hz;
      hz = model_stall();
      #1 chk({tag, "_stall"}, {152'd0, stall_out}, {152'd0, hz});
      if (hz || i_flush) model_clear();
      else model_load();
      @(posedge clk);
      #1 chk({tag, "_regs"}, dut_vec(), model_vec());
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b1, C_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0);
      model_clear();
      repeat (2) @(negedge clk);
      chk("reset_hold", dut_vec(), 153'd0);

      // First capture after reset release
      rst_n = 1'b1;
      drive(1'b1, C_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0);
      cycle("rtype_first");
      chk("rtype_aluop", {151'd0, ex_ALUOp_out}, {151'd0, 2'b10});

      // Asynchronous reset mid-cycle with non-zero registers
      #2 rst_n = 1'b0;
      #1 chk("async_reset", {dut_vec(), stall_out}, 154'd0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;

      // Load-use on rs
      drive(1'b1, C_LW, 5'd2, 5'd5, 5'd0, 1'b0);
      cycle("lu_load");
      drive(1'b1, C_RTYPE, 5'd5, 5'd9, 5'd10, 1'b0);
      #1 chk("lu_rs_stall_hi", {152'd0, stall_out}, {152'd0, 1'b1});
      cycle("lu_bubble");
      chk("lu_bubble_valid", {152'd0, ex_valid_out}, 153'd0);
      cycle("lu_capture");
      chk("lu_capture_valid", {152'd0, ex_valid_out}, {152'd0, 1'b1});

      // $0 never triggers a hazard
      drive(1'b1, C_LW, 5'd3, 5'd0, 5'd0, 1'b0);
      cycle("zero_load");
      drive(1'b1, C_RTYPE, 5'd0, 5'd0, 5'd4, 1'b0);
      cycle("zero_user");

      // Flush of a beq
      drive(1'b1, C_BEQ, 5'd4, 5'd6, 5'd0, 1'b1);
      cycle("flush_beq");
      chk("flush_branch", {150'd0, m_Branch_out, ex_valid_out, wb_RegWrite_out}, 153'd0);

      // sw passthrough
      drive(1'b1, C_SW, 5'd7, 5'd8, 5'd0, 1'b0);
      i_d2 = 32'hDEADBEEF; i_imm = 32'd8;
      cycle("sw");
      chk("sw_fields", {rd_data2_out, imm_ext_out, m_MemWrite_out, ex_ALUSrc_out},
          {32'hDEADBEEF, 32'd8, 1'b1, 1'b1});

      // Simultaneous flush and hazard: one bubble, then capture resumes
      drive(1'b1, C_LW, 5'd1, 5'd11, 5'd0, 1'b0);
      cycle("fh_load");
      drive(1'b1, C_RTYPE, 5'd11, 5'd1, 5'd12, 1'b1);
      cycle("fh_both");
      drive(1'b1, C_RTYPE, 5'd11, 5'd1, 5'd12, 1'b0);
      cycle("fh_resume");

      // Back-to-back dependent loads
      drive(1'b1, C_LW, 5'd1, 5'd7, 5'd0, 1'b0);
      cycle("b2b_first");
      drive(1'b1, C_LW, 5'd7, 5'd8, 5'd0, 1'b0);
      cycle("b2b_bubble");
      cycle("b2b_second");
      chk("b2b_second_load", {151'd0, m_MemRead_out, ex_valid_out}, {151'd0, 2'b11});

      // Reset while stalled abandons the stall
      drive(1'b1, C_LW, 5'd1, 5'd6, 5'd0, 1'b0);
      cycle("rs_load");
      drive(1'b1, C_RTYPE, 5'd6, 5'd2, 5'd3, 1'b0);
      #1 chk("rs_pre_stall", {152'd0, stall_out}, {152'd0, 1'b1});
      #1 rst_n = 1'b0;
      #1 chk("rs_reset_stall", {dut_vec(), stall_out}, 154'd0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      cycle("rs_after");

      // Random instruction stream with a small register window to provoke hazards
      for (int n = 0; n < 300; n++) begin
         logic [8:0] c;
         case ($urandom_range(0, 4))
            0: c = C_RTYPE;
            1: c = C_LW;
            2: c = C_SW;
            3: c = C_BEQ;
            default: c = 9'($urandom);
         endcase
         drive($urandom_range(0, 9) != 0, c, 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
               $urandom_range(0, 9) == 0);
         cycle($sformatf("rand%0d", n));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
